// File: rtl/mem_arbiter_if.sv
// Generic address/data-phase memory channel. The master drives the request;
// the slave answers with accept, response strobe and read data.
interface mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic                req;
    logic                write;
    logic [XLEN/8-1:0]   wstrb;
    logic [XLEN-1:0]     addr;
    logic [XLEN-1:0]     wdata;
    logic                addr_ok;
    logic                data_ok;
    logic [XLEN-1:0]     rdata;

    modport master (
        output req, write, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, write, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one pipelined memory port, with
// anti-starvation for fetch and an owner FIFO routing in-order responses.
module mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  iram,
    mem_arbiter_if.slave  dram,
    mem_arbiter_if.master bus,
    output logic          err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic [DEPTH-1:0] fifo_q, fifo_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;

    logic owner;
    logic req_sel;
    logic fifo_full;
    logic fifo_empty;
    logic fetch_turn;
    logic accept;
    logic pop;
    logic head;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign fetch_turn = iram.req && (starve_q == STARVE_MAX);

    // In HOLD the owner is frozen; otherwise data wins unless fetch has
    // waited through STARVE_LIMIT consecutive data grants.
    always_comb begin
        owner   = OWN_FETCH;
        req_sel = 1'b0;
        if (state_q == S_HOLD) begin
            owner   = owner_q;
            req_sel = owner_q ? dram.req : iram.req;
        end else if (dram.req && !fetch_turn) begin
            owner   = OWN_DATA;
            req_sel = 1'b1;
        end else if (iram.req) begin
            owner   = OWN_FETCH;
            req_sel = 1'b1;
        end
    end

    assign bus.req   = req_sel && !fifo_full;
    assign bus.write = (owner == OWN_DATA) && dram.write;
    assign bus.wstrb = (owner == OWN_DATA) ? dram.wstrb : '0;
    assign bus.addr  = (owner == OWN_DATA) ? dram.addr : iram.addr;
    assign bus.wdata = dram.wdata;

    assign accept       = bus.req && bus.addr_ok;
    assign iram.addr_ok = accept && (owner == OWN_FETCH);
    assign dram.addr_ok = accept && (owner == OWN_DATA);

    // A response with nothing outstanding is a protocol error, not a pop.
    assign pop          = bus.data_ok && !fifo_empty;
    assign head         = fifo_q[rd_ptr_q];
    assign iram.data_ok = pop && (head == OWN_FETCH);
    assign dram.data_ok = pop && (head == OWN_DATA);
    assign iram.rdata   = bus.rdata;
    assign dram.rdata   = bus.rdata;
    assign err          = err_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (accept) begin
            state_d = S_IDLE;
        end else if (bus.req) begin
            state_d = S_HOLD;
            owner_d = owner;
        end else if (state_q == S_HOLD && !req_sel) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (accept && owner == OWN_FETCH) begin
            starve_d = '0;
        end else if (accept && iram.req && starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            fifo_d[wr_ptr_q] = owner;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    assign err_d = err_q || (bus.data_ok && fifo_empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_FETCH;
            starve_q <= '0;
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data/address width.
REQ-002 Parameter DEPTH, default 4 (power of 2, >=2), maximum outstanding bus transactions.
REQ-003 Parameter STARVE_LIMIT, default 3, consecutive data grants allowed while fetch waits.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 iram_req in 1 / iram_addr in XLEN: fetch read request; held stable until iram_addr_ok.
REQ-007 iram_addr_ok out 1 / iram_data_ok out 1 / iram_rdata out XLEN: fetch accept, response strobe, read data.
REQ-008 dram_req in 1 / dram_write in 1 / dram_wstrb in XLEN/8 / dram_addr in XLEN / dram_wdata in XLEN: data request; held stable until dram_addr_ok.
REQ-009 dram_addr_ok out 1 / dram_data_ok out 1 / dram_rdata out XLEN: data accept, response strobe, read data.
REQ-010 bus_req out 1 / bus_write out 1 / bus_wstrb out XLEN/8 / bus_addr out XLEN / bus_wdata out XLEN: shared memory port request.
REQ-011 bus_addr_ok in 1 / bus_data_ok in 1 / bus_rdata in XLEN: port accept, in-order response (reads and writes), read data.
REQ-012 err out 1: sticky protocol-error flag.

Function
REQ-013 Address phase: a transaction is accepted in any cycle with bus_req & bus_addr_ok; exactly one of iram_addr_ok/dram_addr_ok equals that accept, routed to the granted owner.
REQ-014 States IDLE, HOLD. IDLE: owner chosen combinationally same cycle; unaccepted request (bus_req & ~bus_addr_ok) -> HOLD with owner registered. HOLD: owner frozen, bus_* driven from owner's inputs; accept -> IDLE.
REQ-015 IDLE priority: data over fetch, except fetch wins when iram_req and starve_cnt == STARVE_LIMIT.
REQ-016 starve_cnt: increments (saturating at STARVE_LIMIT) on each dram accept while iram_req=1; clears on each iram accept; unchanged otherwise.
REQ-017 bus_write = dram_write and bus_wstrb = dram_wstrb when owner is data; bus_write=0, bus_wstrb=0 when owner is fetch.
REQ-018 Owner-ID FIFO, DEPTH entries, 1 bit per entry (0 fetch, 1 data): push on accept, pop on bus_data_ok; count range 0..DEPTH.
REQ-019 FIFO full (count == DEPTH): bus_req=0, no addr_ok, regardless of same-cycle bus_data_ok; HOLD state persists with bus_req=0.
REQ-020 Response routing: bus_data_ok with FIFO non-empty asserts iram_data_ok or dram_data_ok per FIFO head, same cycle (combinational); iram_rdata = dram_rdata = bus_rdata always.
REQ-021 Simultaneous push and pop when not full: both take effect, count unchanged, pointers wrap modulo DEPTH.
REQ-022 bus_data_ok with FIFO empty: no data_ok to either requester, err set to 1 until reset.
REQ-023 Response for a transaction never precedes the cycle after its accept; same-cycle accept and data_ok refer to an older entry.
REQ-024 No request: bus_req=0, bus_addr/bus_wdata don't-care.

Reset
REQ-025 On rst=1 at a clock edge: state IDLE, FIFO empty (count 0, pointers 0), starve_cnt 0, err 0; in-flight responses discarded.
REQ-026 Resulting output values during/after reset with no inputs active: all *_addr_ok, *_data_ok, bus_req, bus_write = 0.
REQ-027 rst mid-HOLD returns to IDLE; next cycle arbitrates afresh.

Verification
REQ-028 iram_req=1, dram_req=1, bus_addr_ok=1 one cycle -> dram_addr_ok=1, iram_addr_ok=0, FIFO head=1; bus_data_ok next cycle -> dram_data_ok=1.
REQ-029 Both requesting continuously, bus_addr_ok=1 every cycle, immediate responses -> 3 dram accepts then 1 iram accept, repeating 3:1.
REQ-030 iram_req alone, bus_addr_ok=0 for 3 cycles, dram_req rises cycle 2, bus_addr_ok=1 cycle 4 -> iram_addr_ok=1 cycle 4 (HOLD keeps fetch owner).
REQ-031 DEPTH=4, 4 accepts with no data_ok -> cycle 5 bus_req=0; one bus_data_ok -> bus_req=1 next cycle; 4 responses return in accept order.
REQ-032 bus_data_ok=1 with FIFO empty -> no requester data_ok, err=1 and stays 1; rst=1 -> err=0.
REQ-033 Accept and data_ok same cycle with count=2 -> count stays 2, correct owner on head, pointer wrap at DEPTH verified over 10 transactions.
